// File: rtl/uart_core.sv
// Full-duplex 8N1 UART core: free-running oversample tick generator, oversampling receiver
// and transmitter, each with its own soft reset and enable.
module uart_core #(
    parameter int unsigned clk_freq   = 100_000_000,
    parameter int unsigned baud_rate  = 9600,
    parameter int unsigned oversample = 16,
    parameter int unsigned data_bits  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          div_in,
    input  logic                 rx_en,
    input  logic                 rx_rst,
    input  logic                 tx_en,
    input  logic                 tx_rst,
    input  logic                 rx,
    input  logic                 tx_start,
    input  logic [data_bits-1:0] tx_data,
    output logic                 s_tick,
    output logic                 tx,
    output logic [data_bits-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_error,
    output logic                 rx_busy,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int unsigned DEFAULT_DIV = clk_freq / (baud_rate * oversample);
    localparam int TICK_W = $clog2(oversample);
    localparam int BIT_W  = $clog2(data_bits + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(oversample - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(oversample / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_bits - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Baud generator: comparing with >= lets a smaller divisor wrap the counter at once.
    logic [15:0] div;
    logic [15:0] baud_cnt;

    assign div    = (div_in != 16'd0) ? div_in : 16'(DEFAULT_DIV);
    assign s_tick = !rst && (baud_cnt >= div - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || s_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    rx_state_t             rx_state, rx_state_n;
    logic                  rx_meta, rx_sync;
    logic [TICK_W-1:0]     rx_ticks, rx_ticks_n;
    logic [BIT_W-1:0]      rx_bits, rx_bits_n;
    logic [data_bits-1:0]  rx_shift, rx_shift_n, rx_data_n;
    logic                  rx_done_n, rx_error_n;

    always_ff @(posedge clk) begin
        if (rst || rx_rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_ticks <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_state_n;
            rx_ticks <= rx_ticks_n;
            rx_bits  <= rx_bits_n;
            rx_shift <= rx_shift_n;
            rx_data  <= rx_data_n;
            rx_done  <= rx_done_n;
            rx_error <= rx_error_n;
        end
    end

    // RX_WAIT parks the receiver after a framing error until the line returns high.
    always_comb begin
        rx_state_n = rx_state;
        rx_ticks_n = rx_ticks;
        rx_bits_n  = rx_bits;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        rx_done_n  = 1'b0;
        rx_error_n = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_en && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_ticks_n = '0;
                end
            end
            RX_START: begin
                if (s_tick) begin
                    if (rx_ticks == TICK_HALF) begin
                        rx_ticks_n = '0;
                        rx_bits_n  = '0;
                        rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_ticks_n = rx_ticks + TICK_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (s_tick) begin
                    if (rx_ticks == TICK_LAST) begin
                        rx_ticks_n = '0;
                        rx_shift_n = data_bits'({rx_sync, rx_shift} >> 1);
                        rx_bits_n  = rx_bits + BIT_W'(1);
                        if (rx_bits == BIT_LAST) begin
                            rx_state_n = RX_STOP;
                        end
                    end else begin
                        rx_ticks_n = rx_ticks + TICK_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (s_tick) begin
                    if (rx_ticks == TICK_LAST) begin
                        rx_ticks_n = '0;
                        if (rx_sync) begin
                            rx_data_n  = rx_shift;
                            rx_done_n  = 1'b1;
                            rx_state_n = RX_IDLE;
                        end else begin
                            rx_error_n = 1'b1;
                            rx_state_n = RX_WAIT;
                        end
                    end else begin
                        rx_ticks_n = rx_ticks + TICK_W'(1);
                    end
                end
            end
            RX_WAIT: begin
                if (rx_sync) begin
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign rx_busy = (rx_state != RX_IDLE);

    tx_state_t             tx_state, tx_state_n;
    logic [TICK_W-1:0]     tx_ticks, tx_ticks_n;
    logic [BIT_W-1:0]      tx_bits, tx_bits_n;
    logic [data_bits-1:0]  tx_shift, tx_shift_n;
    logic                  tx_n, tx_done_n;

    always_ff @(posedge clk) begin
        if (rst || tx_rst) begin
            tx_state <= TX_IDLE;
            tx_ticks <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_ticks <= tx_ticks_n;
            tx_bits  <= tx_bits_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
            tx_done  <= tx_done_n;
        end
    end

    // The line level is derived from the next state so tx comes straight from a flop.
    always_comb begin
        tx_state_n = tx_state;
        tx_ticks_n = tx_ticks;
        tx_bits_n  = tx_bits;
        tx_shift_n = tx_shift;
        tx_done_n  = 1'b0;
        tx_n       = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tx_start && tx_en) begin
                    tx_shift_n = tx_data;
                    tx_ticks_n = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (s_tick) begin
                    if (tx_ticks == TICK_LAST) begin
                        tx_ticks_n = '0;
                        tx_bits_n  = '0;
                        tx_state_n = TX_DATA;
                    end else begin
                        tx_ticks_n = tx_ticks + TICK_W'(1);
                    end
                end
            end
            TX_DATA: begin
                if (s_tick) begin
                    if (tx_ticks == TICK_LAST) begin
                        tx_ticks_n = '0;
                        tx_shift_n = tx_shift >> 1;
                        tx_bits_n  = tx_bits + BIT_W'(1);
                        if (tx_bits == BIT_LAST) begin
                            tx_state_n = TX_STOP;
                        end
                    end else begin
                        tx_ticks_n = tx_ticks + TICK_W'(1);
                    end
                end
            end
            TX_STOP: begin
                if (s_tick) begin
                    if (tx_ticks == TICK_LAST) begin
                        tx_ticks_n = '0;
                        tx_done_n  = 1'b1;
                        tx_state_n = TX_IDLE;
                    end else begin
                        tx_ticks_n = tx_ticks + TICK_W'(1);
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        case (tx_state_n)
            TX_START: tx_n = 1'b0;
            TX_DATA:  tx_n = tx_shift_n[0];
            default:  tx_n = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_core.sv
// Testbench for uart_core: randomized frames, a queue-based scoreboard and
// independent monitors that decode the serial line and the receiver pulses.
module tb_uart_core;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst, rx_en, rx_rst, tx_en, tx_rst, tx_start;
    logic [15:0] div_in;
    logic [7:0] tx_data;
    logic       rx_drv, loop_sel, rx_line;
    logic       s_tick, tx, rx_done, rx_error, rx_busy, tx_busy, tx_done;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    assign rx_line = loop_sel ? tx : rx_drv;

    uart_core #(
        .clk_freq(100_000_000), .baud_rate(9600), .oversample(OS), .data_bits(8)
    ) dut (
        .clk(clk), .rst(rst), .div_in(div_in), .rx_en(rx_en), .rx_rst(rx_rst),
        .tx_en(tx_en), .tx_rst(tx_rst), .rx(rx_line), .tx_start(tx_start),
        .tx_data(tx_data), .s_tick(s_tick), .tx(tx), .rx_data(rx_data),
        .rx_done(rx_done), .rx_error(rx_error), .rx_busy(rx_busy),
        .tx_busy(tx_busy), .tx_done(tx_done)
    );

    typedef struct packed { logic [7:0] data; logic err; }   rx_exp_t;
    typedef struct packed { logic [7:0] data; logic abort; } tx_exp_t;

    rx_exp_t    rx_q[$];
    tx_exp_t    tx_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         bit_clks = 64;
    logic [7:0] last_good = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one transmit request; the expected frame goes to the scoreboard.
    task automatic applyStimulus(input logic [7:0] d, input bit abort, input bit loopback);
        tx_q.push_back('{data: d, abort: abort});
        if (loopback) begin
            rx_q.push_back('{data: d, err: 1'b0});
            last_good = d;
        end
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic sendRxFrame(input logic [7:0] d, input logic stop_bit, input int tail_low);
        rx_drv = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (bit_clks) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (bit_clks) @(negedge clk);
        if (!stop_bit) repeat (tail_low) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic waitTxDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput(name, 32'd0, 32'd1);
    endtask

    task automatic waitTick();
        bit seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (s_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic measureTick(input string name, input int expected);
        int n = 0;
        waitTick();
        do begin
            @(negedge clk);
            n++;
        end while (!s_tick && n < 5000);
        checkOutput(name, n, expected);
    endtask

    // Receiver monitor: every done/error pulse must match the next expected frame.
    always @(negedge clk) begin
        if (!rst && (rx_done || rx_error)) begin
            if (rx_q.size() == 0) begin
                checkOutput("rx_unexpected_pulse", {30'd0, rx_done, rx_error}, 32'd0);
            end else begin
                rx_exp_t e;
                e = rx_q.pop_front();
                checkOutput("rx_pulse_kind", {30'd0, rx_done, rx_error}, e.err ? 32'd1 : 32'd2);
                checkOutput("rx_data", rx_data, e.data);
            end
        end
    end

    // Transmit monitor: decodes the line at mid-bit, counting oversample ticks while busy.
    int       tx_ticks = 0;
    logic [9:0] tx_bits = '0;
    bit       tx_in_frame = 1'b0;
    bit       tx_have = 1'b0;
    tx_exp_t  tx_cur;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_busy) begin
                if (!tx_in_frame) begin
                    tx_in_frame = 1'b1;
                    tx_ticks    = 0;
                    tx_bits     = '0;
                    if (tx_q.size() == 0) begin
                        tx_have = 1'b0;
                        checkOutput("tx_unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        tx_have = 1'b1;
                        tx_cur  = tx_q.pop_front();
                    end
                end
                if (s_tick) begin
                    tx_ticks++;
                    if (tx_ticks % OS == OS / 2 && tx_ticks < 10 * OS)
                        tx_bits[tx_ticks / OS] = tx;
                end
            end else if (tx_in_frame) begin
                tx_in_frame = 1'b0;
                if (tx_have) begin
                    if (tx_cur.abort) begin
                        checkOutput("tx_abort_no_done", tx_done, 32'd0);
                        checkOutput("tx_abort_line", tx, 32'd1);
                    end else begin
                        checkOutput("tx_done_pulse", tx_done, 32'd1);
                        checkOutput("tx_busy_ticks", tx_ticks, 10 * OS);
                        checkOutput("tx_start_bit", tx_bits[0], 32'd0);
                        checkOutput("tx_data_bits", tx_bits[8:1], tx_cur.data);
                        checkOutput("tx_stop_bit", tx_bits[9], 32'd1);
                    end
                end
            end else if (tx_done) begin
                checkOutput("tx_done_spurious", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] lb [6];
        logic [7:0] d;
        rst = 1'b1; div_in = 16'd0; rx_en = 1'b1; rx_rst = 1'b0; tx_en = 1'b1; tx_rst = 1'b0;
        tx_start = 1'b0; tx_data = 8'h00; rx_drv = 1'b1; loop_sel = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("rst_tx", tx, 32'd1);
        checkOutput("rst_rx_data", rx_data, 32'd0);
        checkOutput("rst_flags", {rx_done, rx_error, rx_busy, tx_busy, tx_done, s_tick}, 32'd0);
        rst = 1'b0;

        $display("[TB] baud tick periods");
        measureTick("tick_period_default", 651);
        measureTick("tick_period_default_2", 651);
        div_in = 16'd10;
        measureTick("tick_period_div10", 10);
        measureTick("tick_period_div10_2", 10);
        div_in = 16'd4;
        bit_clks = OS * 4;
        measureTick("tick_period_div4", 4);

        $display("[TB] transmit 0x55");
        applyStimulus(8'h55, 1'b0, 1'b0);
        waitTxDone("tx_55_timeout");
        repeat (bit_clks) @(negedge clk);

        $display("[TB] back-to-back loopback");
        lb[0] = 8'($urandom); lb[1] = 8'($urandom);
        lb[2] = 8'h55; lb[3] = 8'hF1; lb[4] = 8'hA3; lb[5] = 8'h3C;
        loop_sel = 1'b1;
        applyStimulus(lb[0], 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            waitTxDone("loopback_timeout");
            if (k < 5) applyStimulus(lb[k + 1], 1'b0, 1'b1);
        end
        repeat (2 * bit_clks) @(negedge clk);
        loop_sel = 1'b0;

        $display("[TB] framing error with line held low");
        rx_q.push_back('{data: last_good, err: 1'b1});
        sendRxFrame(8'hC7, 1'b0, 3 * bit_clks);
        checkOutput("rx_data_kept", rx_data, 32'h3C);
        checkOutput("rx_idle_after_error", rx_busy, 32'd0);

        $display("[TB] start-bit glitch");
        rx_drv = 1'b0;
        repeat (3 * 4) @(negedge clk);
        checkOutput("glitch_busy_entered", rx_busy, 32'd1);
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (bit_clks) @(negedge clk);
        checkOutput("glitch_rejected", rx_busy, 32'd0);

        $display("[TB] receiver disabled");
        rx_en = 1'b0;
        sendRxFrame(8'($urandom), 1'b1, 0);
        checkOutput("rx_disabled_busy", rx_busy, 32'd0);
        rx_en = 1'b1;

        $display("[TB] transmit enables and busy rejection");
        tx_en = 1'b0;
        tx_data = 8'hA5; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("tx_disabled_busy", tx_busy, 32'd0);
        tx_en = 1'b1;
        d = 8'($urandom);
        applyStimulus(d, 1'b0, 1'b0);
        repeat (50 * 4) @(negedge clk);
        tx_data = ~d; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        checkOutput("ignored_start_busy", tx_busy, 32'd1);
        waitTxDone("tx_ignore_timeout");
        repeat (bit_clks) @(negedge clk);

        $display("[TB] transmitter soft reset mid-frame");
        applyStimulus(8'($urandom), 1'b1, 1'b0);
        repeat (70 * 4) @(negedge clk);
        tx_rst = 1'b1;
        @(negedge clk);
        tx_rst = 1'b0;
        checkOutput("tx_rst_line", tx, 32'd1);
        checkOutput("tx_rst_busy", tx_busy, 32'd0);
        measureTick("tick_after_tx_rst", 4);
        repeat (bit_clks) @(negedge clk);

        $display("[TB] receiver soft reset mid-frame");
        rx_drv = 1'b0;
        repeat (3 * bit_clks) @(negedge clk);
        checkOutput("rx_rst_pre_busy", rx_busy, 32'd1);
        rx_drv = 1'b1; rx_rst = 1'b1;
        @(negedge clk);
        checkOutput("rx_rst_busy", rx_busy, 32'd0);
        repeat (2) @(negedge clk);
        rx_rst = 1'b0;
        last_good = 8'h00;
        checkOutput("rx_rst_data", rx_data, 32'd0);
        repeat (2 * bit_clks) @(negedge clk);

        $display("[TB] random receive frames");
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            rx_q.push_back('{data: d, err: 1'b0});
            last_good = d;
            sendRxFrame(d, 1'b1, 0);
        end

        repeat (bit_clks) @(negedge clk);
        checkOutput("rx_queue_drained", rx_q.size(), 32'd0);
        checkOutput("tx_queue_drained", tx_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
